msdap_ctrl: RTL and testbench
=============================

# msdap_ctrl

Sequencing controller for the MSDAP distributed-arithmetic datapath. Loads the 16 Rj group sizes and 256 coefficient entries into their memories, manages the 256-entry circular sample buffer, and issues one compute request per accepted sample. The datapath computes the Uj partial sums and the shift-accumulate. It also performs power-on/clear zeroing of the sample buffer and enters a sleep mode on long runs of zero input.

## Interface
- RJ_COUNT, 16, number of Rj entries
- COEFF_COUNT, 256, number of coefficient entries
- ZERO_LIMIT, 800, consecutive zero samples before sleeping
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  advance out of WAIT_RJ / WAIT_COEFF / WAIT_INPUT
- clear  in  1  request to flush sample buffer (WORKING/SLEEPING only)
- in_word  in  16  Rj / coefficient / sample word
- in_valid  in  1  in_word valid
- in_ready  out  1  controller accepts in_word this cycle
- rj_we, rj_addr[3:0], rj_wdata[7:0]  out  Rj memory write port
- coeff_we, coeff_addr[7:0], coeff_wdata[8:0]  out  coefficient memory write port; bit 8 = sign
- sample_we, sample_addr[7:0], sample_wdata[15:0]  out  sample buffer write port
- compute_start  out  1  one-cycle request to datapath
- compute_base  out  8  address of newest sample; valid with compute_start
- compute_done  in  1  one-cycle completion pulse from datapath
- zero_out  out  1  one-cycle pulse: datapath emits zero result for this sample
- status  out  4  current state encoding

## Operation
- States and encodings:
  - INIT=0
  - WAIT_RJ=1
  - READ_RJ=2
  - WAIT_COEFF=3
  - READ_COEFF=4
  - WAIT_INPUT=5
  - WORKING=6
  - CLEARING=7
  - SLEEPING=8
- A word is accepted when in_valid & in_ready.
- INIT / CLEARING:
  - sample_we=1 and sample_wdata=0 for 256 cycles; sample_addr runs 0..255.
  - in_ready=0.
  - wr_ptr and zero counter are cleared.
  - Exit: INIT -> WAIT_RJ, CLEARING -> WORKING.
- WAIT_* states:
  - in_ready=0.
  - start=1 moves to the next state: WAIT_RJ -> READ_RJ, WAIT_COEFF -> READ_COEFF, WAIT_INPUT -> WORKING.
  - start is ignored in every other state.
- READ_RJ:
  - in_ready=1.
  - Accepted word n (n = 0..RJ_COUNT-1) writes rj_addr=n, rj_wdata=in_word[7:0].
  - After the 16th word -> WAIT_COEFF.
- READ_COEFF:
  - Same scheme with coeff_wdata=in_word[8:0].
  - After the 256th word -> WAIT_INPUT.
- WORKING:
  - in_ready=1 when not busy.
  - An accepted sample writes sample_addr=wr_ptr and sets busy.
  - compute_start is issued with compute_base=wr_ptr, then wr_ptr increments mod 256 (255 -> 0).
  - busy clears on compute_done; compute_done while not busy is ignored.
- Zero detection:
  - zero_cnt increments on each accepted zero sample and resets to 0 on any nonzero sample.
  - zero_cnt saturates at ZERO_LIMIT.
  - When compute_done arrives with zero_cnt==ZERO_LIMIT -> SLEEPING.
- SLEEPING:
  - in_ready=1.
  - Accepted zero sample: written to the buffer, wr_ptr advances, zero_out pulses, no compute.
  - Accepted nonzero sample: handled exactly as in WORKING (write, compute_start); state -> WORKING; zero_cnt=0.
- clear:
  - Latched as pending when high in WORKING or SLEEPING.
  - Acted on only when not busy, which may be immediately or at compute_done. State -> CLEARING.
  - No sample is accepted while clear is pending.

## Timing
- All outputs are registered.
- Reset values: every output 0, status=0. Internal counters and pointers are 0; busy and clear pending are cleared.
- Reset is asynchronous and takes effect at any point, including mid-load or mid-compute. Afterwards the controller re-enters INIT, and the full 256-cycle zeroing repeats.
- Accept at edge N:
  - The write strobe (rj_we / coeff_we / sample_we) is high for cycle N+1.
  - in_ready drops in cycle N+1 in WORKING.
  - compute_start is high in cycle N+2, after the write has landed.
- Once busy clears on compute_done, in_ready is high the following cycle.
- Sample throughput is at most one sample per (datapath latency + 3) cycles.
- State changes take effect at the edge; status reflects the new state the cycle after the triggering event.
- In READ_RJ and READ_COEFF in_ready stays high: back-to-back words are accepted every cycle.

## Configuration
- MSDAP_SLEEP_EN:
  - Defined: zero counter, SLEEPING state and zero_out are present.
  - Undefined: no zero counter; the controller never leaves WORKING except via clear; zero_out is tied 0; status never reads 8.

## Test plan
- Reset release -> status=0; sample_we=1 with addr 0..255 and data 0 over 256 cycles; then status=1, in_ready=0.
- start, then 16 words 0x0020 back-to-back:
  - Expect rj_we pulses at addr 0..15 with data 0x20, then status=3.
  - start, then 256 words 0x01xx: expect coeff_wdata[8]=1 and addr 0..255, then status=5.
- start; sample 0x1234:
  - sample_we at addr 0 with data 0x1234; compute_start one cycle later with base 0.
  - in_ready stays low until compute_done.
  - 257th sample writes addr 0 (wrap).
- 800 zero samples with compute_done each -> status=8 after the 800th done.
  - A further zero pulses zero_out with no compute_start.
  - Sample 0x0001 -> compute_start and status=6.
- clear asserted while busy -> status stays 6 until compute_done; then status=7 for 256 zeroing cycles; then status=6 with the next sample written to addr 0.
- Assert reset during READ_COEFF at word 100 -> all outputs 0 immediately; INIT zeroing restarts.

Source files
------------

// File: rtl/msdap_ctrl_if.sv
// msdap_ctrl_if: input stream, memory write ports and
// datapath compute handshake of the MSDAP controller.
interface msdap_ctrl_if;
  logic [15:0] in_word;
  logic        in_valid;
  logic        in_ready;
  logic        rj_we;
  logic [3:0]  rj_addr;
  logic [7:0]  rj_wdata;
  logic        coeff_we;
  logic [7:0]  coeff_addr;
  logic [8:0]  coeff_wdata;
  logic        sample_we;
  logic [7:0]  sample_addr;
  logic [15:0] sample_wdata;
  logic        compute_start;
  logic [7:0]  compute_base;
  logic        compute_done;
  logic        zero_out;

  modport master (
    input  in_word, in_valid, compute_done,
    output in_ready,
    output rj_we, rj_addr, rj_wdata,
    output coeff_we, coeff_addr, coeff_wdata,
    output sample_we, sample_addr, sample_wdata,
    output compute_start, compute_base, zero_out
  );

  modport slave (
    output in_word, in_valid, compute_done,
    input  in_ready,
    input  rj_we, rj_addr, rj_wdata,
    input  coeff_we, coeff_addr, coeff_wdata,
    input  sample_we, sample_addr, sample_wdata,
    input  compute_start, compute_base, zero_out
  );
endinterface

// File: rtl/msdap_ctrl.sv
// msdap_ctrl: MSDAP load/sample sequencer with buffer zeroing.
// Optional zero-run sleep mode enabled by MSDAP_SLEEP_EN.
module msdap_ctrl #(
  parameter int RJ_COUNT    = 16,
  parameter int COEFF_COUNT = 256
`ifdef MSDAP_SLEEP_EN
  , parameter int ZERO_LIMIT = 800
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        clear,
  output logic [3:0]  status,
  msdap_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    INIT       = 4'd0,
    WAIT_RJ    = 4'd1,
    READ_RJ    = 4'd2,
    WAIT_COEFF = 4'd3,
    READ_COEFF = 4'd4,
    WAIT_INPUT = 4'd5,
    WORKING    = 4'd6,
    CLEARING   = 4'd7,
    SLEEPING   = 4'd8
  } state_t;

  state_t      state;
  logic [8:0]  cnt;
  logic [7:0]  wr_ptr;
  logic        busy;
  logic        clr_pend;
  logic        cs_pend;
  logic        acc;
  logic        clr_req;

`ifdef MSDAP_SLEEP_EN
  localparam logic [9:0] ZLIM = 10'(ZERO_LIMIT);
  logic [9:0]  zero_cnt;
  logic        zo_pend;
  logic        zero_word;
  assign zero_word = (bus.in_word == 16'd0);
`endif

  assign acc     = bus.in_valid & bus.in_ready;
  assign clr_req = clr_pend | clear;
  assign status  = state;

  // sequencer: state, counters and all registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= INIT;
      cnt               <= '0;
      wr_ptr            <= '0;
      busy              <= 1'b0;
      clr_pend          <= 1'b0;
      cs_pend           <= 1'b0;
      bus.in_ready      <= 1'b0;
      bus.rj_we         <= 1'b0;
      bus.rj_addr       <= '0;
      bus.rj_wdata      <= '0;
      bus.coeff_we      <= 1'b0;
      bus.coeff_addr    <= '0;
      bus.coeff_wdata   <= '0;
      bus.sample_we     <= 1'b0;
      bus.sample_addr   <= '0;
      bus.sample_wdata  <= '0;
      bus.compute_start <= 1'b0;
      bus.compute_base  <= '0;
      bus.zero_out      <= 1'b0;
`ifdef MSDAP_SLEEP_EN
      zero_cnt          <= '0;
      zo_pend           <= 1'b0;
`endif
    end else begin
      bus.rj_we         <= 1'b0;
      bus.coeff_we      <= 1'b0;
      bus.sample_we     <= 1'b0;
      bus.compute_start <= 1'b0;
      bus.zero_out      <= 1'b0;

      // request issues one cycle after the sample write lands
      if (cs_pend) begin
        bus.compute_start <= 1'b1;
        bus.compute_base  <= bus.sample_addr;
        cs_pend           <= 1'b0;
      end
`ifdef MSDAP_SLEEP_EN
      if (zo_pend) begin
        bus.zero_out <= 1'b1;
        zo_pend      <= 1'b0;
      end
`endif

      unique case (state)
        INIT, CLEARING: begin
          wr_ptr <= '0;
`ifdef MSDAP_SLEEP_EN
          zero_cnt <= '0;
`endif
          if (cnt[8]) begin
            cnt <= '0;
            if (state == INIT) begin
              state <= WAIT_RJ;
            end else begin
              state        <= WORKING;
              bus.in_ready <= 1'b1;
            end
          end else begin
            bus.sample_we    <= 1'b1;
            bus.sample_addr  <= cnt[7:0];
            bus.sample_wdata <= '0;
            cnt              <= cnt + 9'd1;
          end
        end
        WAIT_RJ: begin
          if (start) begin
            state        <= READ_RJ;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
          end
        end
        READ_RJ: begin
          if (acc) begin
            bus.rj_we    <= 1'b1;
            bus.rj_addr  <= cnt[3:0];
            bus.rj_wdata <= bus.in_word[7:0];
            if (cnt == 9'(RJ_COUNT - 1)) begin
              state        <= WAIT_COEFF;
              cnt          <= '0;
              bus.in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        WAIT_COEFF: begin
          if (start) begin
            state        <= READ_COEFF;
            cnt          <= '0;
            bus.in_ready <= 1'b1;
          end
        end
        READ_COEFF: begin
          if (acc) begin
            bus.coeff_we    <= 1'b1;
            bus.coeff_addr  <= cnt[7:0];
            bus.coeff_wdata <= bus.in_word[8:0];
            if (cnt == 9'(COEFF_COUNT - 1)) begin
              state        <= WAIT_INPUT;
              cnt          <= '0;
              bus.in_ready <= 1'b0;
            end else begin
              cnt <= cnt + 9'd1;
            end
          end
        end
        WAIT_INPUT: begin
          if (start) begin
            state        <= WORKING;
            bus.in_ready <= 1'b1;
          end
        end
        WORKING: begin
          if (acc) begin
            bus.sample_we    <= 1'b1;
            bus.sample_addr  <= wr_ptr;
            bus.sample_wdata <= bus.in_word;
            wr_ptr           <= wr_ptr + 8'd1;
            busy             <= 1'b1;
            cs_pend          <= 1'b1;
            bus.in_ready     <= 1'b0;
            clr_pend         <= clr_req;
`ifdef MSDAP_SLEEP_EN
            if (!zero_word)
              zero_cnt <= '0;
            else if (zero_cnt != ZLIM)
              zero_cnt <= zero_cnt + 10'd1;
`endif
          end else if (busy) begin
            if (bus.compute_done && !cs_pend) begin
              busy <= 1'b0;
              if (clr_req) begin
                state            <= CLEARING;
                clr_pend         <= 1'b0;
                bus.sample_we    <= 1'b1;
                bus.sample_addr  <= '0;
                bus.sample_wdata <= '0;
                cnt              <= 9'd1;
                wr_ptr           <= '0;
              end else begin
                bus.in_ready <= 1'b1;
`ifdef MSDAP_SLEEP_EN
                if (zero_cnt == ZLIM)
                  state <= SLEEPING;
`endif
              end
            end else begin
              clr_pend <= clr_req;
            end
          end else if (clr_req) begin
            state            <= CLEARING;
            clr_pend         <= 1'b0;
            bus.in_ready     <= 1'b0;
            bus.sample_we    <= 1'b1;
            bus.sample_addr  <= '0;
            bus.sample_wdata <= '0;
            cnt              <= 9'd1;
            wr_ptr           <= '0;
          end
        end
`ifdef MSDAP_SLEEP_EN
        SLEEPING: begin
          if (acc) begin
            bus.sample_we    <= 1'b1;
            bus.sample_addr  <= wr_ptr;
            bus.sample_wdata <= bus.in_word;
            wr_ptr           <= wr_ptr + 8'd1;
            clr_pend         <= clr_req;
            if (zero_word) begin
              zo_pend      <= 1'b1;
              bus.in_ready <= !clr_req;
            end else begin
              state        <= WORKING;
              busy         <= 1'b1;
              cs_pend      <= 1'b1;
              zero_cnt     <= '0;
              bus.in_ready <= 1'b0;
            end
          end else if (clr_req) begin
            state            <= CLEARING;
            clr_pend         <= 1'b0;
            bus.in_ready     <= 1'b0;
            bus.sample_we    <= 1'b1;
            bus.sample_addr  <= '0;
            bus.sample_wdata <= '0;
            cnt              <= 9'd1;
            wr_ptr           <= '0;
          end
        end
`endif
        default: begin
          state        <= INIT;
          cnt          <= '0;
          bus.in_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_msdap_ctrl.sv
// tb_msdap_ctrl: directed bench with a queue-based expectation
// model and a per-cycle compare process on the negative edge.
module tb_msdap_ctrl;

`ifdef MSDAP_SLEEP_EN
  localparam bit SLEEP_EN = 1'b1;
`else
  localparam bit SLEEP_EN = 1'b0;
`endif
  localparam int ZLIM = 800;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       clear;
  logic [3:0] status;

  msdap_ctrl_if bus();

  msdap_ctrl dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .clear(clear),
    .status(status),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]  a;
    logic [15:0] d;
  } wr_t;

  int checks = 0;
  int errors = 0;

  wr_t        q_rj[$];
  wr_t        q_cf[$];
  wr_t        q_sm[$];
  logic [7:0] q_cs[$];
  int         zo_exp = 0;

  int m_ptr   = 0;
  int m_zc    = 0;
  bit m_sleep = 1'b0;

  task automatic chk(input string nm, input logic [79:0] act,
                     input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    checks++;
    errors++;
    $display("FAIL %s got unexpected event want none", nm);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [79:0] outs();
    return 80'({bus.in_ready, bus.rj_we, bus.rj_addr, bus.rj_wdata,
                bus.coeff_we, bus.coeff_addr, bus.coeff_wdata,
                bus.sample_we, bus.sample_addr, bus.sample_wdata,
                bus.compute_start, bus.compute_base, bus.zero_out,
                status});
  endfunction

  // every strobe must match the next expected transaction
  always @(negedge clk) begin : cmp
    wr_t w;
    if (!reset) begin
      if (bus.rj_we) begin
        if (q_rj.size() == 0) bad("rj_we");
        else begin
          w = q_rj.pop_front();
          chk("rj_addr", 80'(bus.rj_addr), 80'(w.a));
          chk("rj_data", 80'(bus.rj_wdata), 80'(w.d));
        end
      end
      if (bus.coeff_we) begin
        if (q_cf.size() == 0) bad("coeff_we");
        else begin
          w = q_cf.pop_front();
          chk("coeff_addr", 80'(bus.coeff_addr), 80'(w.a));
          chk("coeff_data", 80'(bus.coeff_wdata), 80'(w.d));
        end
      end
      if (bus.sample_we) begin
        if (q_sm.size() == 0) bad("sample_we");
        else begin
          w = q_sm.pop_front();
          chk("sample_addr", 80'(bus.sample_addr), 80'(w.a));
          chk("sample_data", 80'(bus.sample_wdata), 80'(w.d));
        end
      end
      if (bus.compute_start) begin
        if (q_cs.size() == 0) bad("compute_start");
        else chk("compute_base", 80'(bus.compute_base),
                 80'(q_cs.pop_front()));
      end
      if (bus.zero_out) begin
        if (zo_exp == 0) bad("zero_out");
        else zo_exp--;
      end
    end
  end

  task automatic do_reset;
    int n;
    int nwe;
    reset = 1'b1;
    q_rj.delete();
    q_cf.delete();
    q_sm.delete();
    q_cs.delete();
    zo_exp  = 0;
    m_ptr   = 0;
    m_zc    = 0;
    m_sleep = 1'b0;
    tick;
    tick;
    chk("reset_outs", outs(), 80'd0);
    reset = 1'b0;
    for (int i = 0; i < 256; i++)
      q_sm.push_back('{a: 8'(i), d: 16'h0000});
    n = 0;
    nwe = 0;
    while (status != 4'd1 && n < 400) begin
      tick;
      n++;
      if (bus.sample_we) nwe++;
    end
    chk("init_writes", 80'(nwe), 80'd256);
    chk("init_status", 80'(status), 80'd1);
    chk("init_ready", 80'(bus.in_ready), 80'd0);
  endtask

  task automatic load_rj;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("rj_status", 80'(status), 80'd2);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_word = 16'h0020;
      chk("rj_ready", 80'(bus.in_ready), 80'd1);
      q_rj.push_back('{a: 8'(i), d: 16'h0020});
      tick;
    end
    bus.in_valid = 1'b0;
    chk("rj_done_status", 80'(status), 80'd3);
    chk("rj_done_ready", 80'(bus.in_ready), 80'd0);
  endtask

  task automatic load_coeff(input int cnt);
    logic [15:0] w;
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("cf_status", 80'(status), 80'd4);
    bus.in_valid = 1'b1;
    for (int i = 0; i < cnt; i++) begin
      w = 16'h0100 | 16'(i[7:0]);
      bus.in_word = w;
      chk("cf_ready", 80'(bus.in_ready), 80'd1);
      q_cf.push_back('{a: 8'(i), d: w & 16'h01ff});
      tick;
      if (i == 50) chk("cf_sign", 80'(bus.coeff_wdata[8]), 80'd1);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic finish_compute(input int lat, input bit to_clear);
    for (int i = 0; i < lat; i++) begin
      tick;
      chk("busy_ready", 80'(bus.in_ready), 80'd0);
    end
    bus.compute_done = 1'b1;
    tick;
    bus.compute_done = 1'b0;
    if (!to_clear) begin
      if (SLEEP_EN && m_zc == ZLIM) m_sleep = 1'b1;
      chk("done_ready", 80'(bus.in_ready), 80'd1);
      chk("done_status", 80'(status), m_sleep ? 80'd8 : 80'd6);
    end
  endtask

  task automatic send_sample(input logic [15:0] w, input int lat,
                             input bit do_done);
    int n;
    bit zpath;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      tick;
      n++;
    end
    if (!bus.in_ready) begin
      bad("in_ready_timeout");
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_word  = w;
    q_sm.push_back('{a: 8'(m_ptr), d: w});
    zpath = m_sleep && (w == 16'd0);
    if (zpath) zo_exp++;
    else begin
      q_cs.push_back(8'(m_ptr));
      m_sleep = 1'b0;
    end
    m_ptr = (m_ptr + 1) % 256;
    if (w == 16'd0) m_zc = (m_zc < ZLIM) ? m_zc + 1 : ZLIM;
    else m_zc = 0;
    tick;
    bus.in_valid = 1'b0;
    if (!zpath) begin
      chk("acc_we", 80'(bus.sample_we), 80'd1);
      chk("acc_ready_drop", 80'(bus.in_ready), 80'd0);
      chk("acc_cs_early", 80'(bus.compute_start), 80'd0);
      tick;
      chk("acc_cs", 80'(bus.compute_start), 80'd1);
      if (do_done) finish_compute(lat, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    reset            = 1'b1;
    start            = 1'b0;
    clear            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.in_word      = '0;
    bus.compute_done = 1'b0;

    do_reset();
    load_rj();
    load_coeff(256);
    chk("cf_done_status", 80'(status), 80'd5);
    chk("cf_done_ready", 80'(bus.in_ready), 80'd0);

    start = 1'b1;
    tick;
    start = 1'b0;
    chk("work_status", 80'(status), 80'd6);
    chk("work_ready", 80'(bus.in_ready), 80'd1);

    send_sample(16'h1234, 3, 1'b0);
    chk("s0_addr", 80'(bus.sample_addr), 80'd0);
    chk("s0_data", 80'(bus.sample_wdata), 80'h1234);
    chk("s0_base", 80'(bus.compute_base), 80'd0);
    finish_compute(3, 1'b0);

    for (int i = 1; i <= 256; i++)
      send_sample(16'(i * 37 + 1), 1, 1'b1);
    chk("wrap_addr", 80'(bus.sample_addr), 80'd0);
    chk("wrap_base", 80'(bus.compute_base), 80'd0);

    for (int i = 0; i < 800; i++)
      send_sample(16'h0000, 1, 1'b1);
    chk("zero_run_status", 80'(status), SLEEP_EN ? 80'd8 : 80'd6);

`ifdef MSDAP_SLEEP_EN
    send_sample(16'h0000, 1, 1'b1);
    chk("zo_we", 80'(bus.sample_we), 80'd1);
    chk("zo_ready", 80'(bus.in_ready), 80'd1);
    tick;
    chk("zo_pulse", 80'(bus.zero_out), 80'd1);
    chk("zo_no_cs", 80'(bus.compute_start), 80'd0);
    chk("zo_status", 80'(status), 80'd8);
`else
    send_sample(16'h0000, 1, 1'b1);
    chk("no_sleep_zo", 80'(bus.zero_out), 80'd0);
`endif

    send_sample(16'h0001, 1, 1'b1);
    chk("wake_status", 80'(status), 80'd6);

    send_sample(16'h0055, 1, 1'b0);
    clear = 1'b1;
    tick;
    clear = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("clr_hold_status", 80'(status), 80'd6);
      chk("clr_hold_ready", 80'(bus.in_ready), 80'd0);
    end
    for (int i = 0; i < 256; i++)
      q_sm.push_back('{a: 8'(i), d: 16'h0000});
    m_ptr = 0;
    m_zc  = 0;
    finish_compute(0, 1'b1);
    chk("clr_status", 80'(status), 80'd7);
    n = 0;
    while (status == 4'd7 && n < 400) begin
      n++;
      tick;
    end
    chk("clr_cycles", 80'(n), 80'd256);
    chk("clr_exit_status", 80'(status), 80'd6);
    chk("clr_exit_ready", 80'(bus.in_ready), 80'd1);
    send_sample(16'h0abc, 2, 1'b1);
    chk("clr_next_addr", 80'(bus.sample_addr), 80'd0);

    do_reset();
    load_rj();
    load_coeff(100);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_outs", outs(), 80'd0);
    do_reset();

    repeat (4) tick;
    chk("left_rj", 80'(q_rj.size()), 80'd0);
    chk("left_cf", 80'(q_cf.size()), 80'd0);
    chk("left_sm", 80'(q_sm.size()), 80'd0);
    chk("left_cs", 80'(q_cs.size()), 80'd0);
    chk("left_zo", 80'(zo_exp), 80'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
